// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Summary  : Bit-serial WIDTH-bit adder with carry-in. One full-adder cell
//             and one carry flop process the operands LSB-first over a
//             valid/ready handshake on each side.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0]    c_IDLE = 2'd0;
   localparam logic [1:0]    c_RUN  = 2'd1;
   localparam logic [1:0]    c_DONE = 2'd2;
   localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_maj;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   // The single full-adder cell
   assign w_s       = r_sa[0] ^ r_sb[0] ^ r_carry;
   assign w_maj     = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
   assign w_last    = (r_cnt == c_LAST);
   assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (in_valid)  w_state_nxt = c_RUN;
         c_RUN:   if (w_last)    w_state_nxt = c_DONE;
         c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == c_IDLE);
      busy      = (r_state == c_RUN);
      out_valid = (r_state == c_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (in_valid) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_res   <= '0;
               end
            end
            c_RUN: begin
               r_sa    <= r_sa >> 1;
               r_sb    <= r_sb >> 1;
               r_carry <= w_maj;
               r_res   <= w_res_nxt;
               r_cnt   <= r_cnt + CW'(1);
               // Outputs update only on completion so they hold across the next op
               if (w_last) begin
                  r_sum  <= w_res_nxt;
                  r_cout <= w_maj;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Summary  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [W-1:0] a, b, sum;

   logic         iv1, ir1, ci1, ov1, or1, co1, bz1;
   logic [0:0]   a1, b1, s1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
      .sum(s1), .cout(co1), .busy(bz1)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int hold, input bit pulse,
                         output logic [W-1:0] rs, output logic rc);
      int lat;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      chk("busy_run", busy, 1);
      chk("in_ready_run", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (pulse && lat == 3) begin
            a = 8'h11; b = 8'h22; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", lat, W);
      chk("busy_done", busy, 0);
      rs = sum;
      rc = cout;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", sum, rs);
         chk("hold_cout", cout, rc);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("in_ready_after_hs", in_ready, 1);
      chk("valid_after_hs", out_valid, 0);
   endtask

   logic [W-1:0] rs;
   logic         rc;
   logic [W:0]   m;
   logic [W:0]   q[$];
   int           acc_cyc[$];

   initial begin
      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[6] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, rs, rc);
         chk("vec_sum", rs, vecs[i].exp_sum);
         chk("vec_cout", rc, vecs[i].exp_cout);
      end

      // Result held under back-pressure, then in_valid pulse during RUN
      run_op(8'h35, 8'h4A, 1'b0, 5, 1'b0, rs, rc);
      chk("bp_sum", rs, 8'h7F);
      run_op(8'h01, 8'h02, 1'b1, 1, 1'b1, rs, rc);
      chk("ignore_sum", rs, 8'h04);
      chk("ignore_cout", rc, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, rs, rc);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      a = 8'hC3; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
      run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, rs, rc);
      chk("post_rst_sum", rs, 8'h00);
      chk("post_rst_cout", rc, 1);

      // Random single ops against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra, rb;
         logic         rci;
         ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
         m = model(ra, rb, rci);
         run_op(ra, rb, rci, int'($urandom_range(0, 2)), 1'($urandom), rs, rc);
         chk("rand_sum", rs, m[W-1:0]);
         chk("rand_cout", rc, m[W]);
      end

      // Back-to-back streaming with in_valid and out_ready held high
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("b2b_unexpected_valid", 1, 0);
            end else begin
               m = q.pop_front();
               chk("b2b_sum", sum, m[W-1:0]);
               chk("b2b_cout", cout, m[W]);
            end
         end
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if (in_ready) begin
            q.push_back(model(a, b, cin));
            acc_cyc.push_back(cyc);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], W + 2);
      chk("b2b_accepts", acc_cyc.size() >= 5, 1);
      out_ready = 1'b0;

      // WIDTH=1 instance, all operand combinations
      for (int k = 0; k < 8; k++) begin
         logic [2:0] kv;
         kv = 3'(k);
         m = model(W'(kv[0]), W'(kv[1]), kv[2]);
         @(negedge clk);
         chk("w1_in_ready", ir1, 1);
         a1 = kv[0]; b1 = kv[1]; ci1 = kv[2]; iv1 = 1'b1;
         @(negedge clk);
         iv1 = 1'b0;
         chk("w1_busy", bz1, 1);
         chk("w1_not_valid", ov1, 0);
         @(negedge clk);
         chk("w1_valid", ov1, 1);
         chk("w1_sum", s1, m[0]);
         chk("w1_cout", co1, m[1]);
         or1 = 1'b1;
         @(negedge clk);
         or1 = 1'b0;
         chk("w1_ready_again", ir1, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
